// File: rtl/pe_acc_pkg.sv
// Shared types and defaults for the PE partial-sum collector.
// Provides the FSM state encoding, default widths and a sign-extend helper.
// Imported by the collector and its interface.
package pe_acc_pkg;

    localparam int PROD_W_DEF    = 13;
    localparam int ACC_W_DEF     = 24;
    localparam int MAX_BEATS_DEF = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Sign-extend the low w bits of v to 64 bits; callers cast down to their width.
    function automatic logic signed [63:0] sext64(input logic [63:0] v, input int unsigned w);
        logic signed [63:0] t;
        t = v << (64 - w);
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/pe_acc_collector_if.sv
// Beat-in / result-out bundle between the PE, the collector and the requant stage.
// slave: collector side; master: upstream controller plus downstream consumer.
// CNT_W must equal $clog2(MAX_BEATS)+1 of the attached collector.
interface pe_acc_collector_if #(
    parameter int PROD_W = pe_acc_pkg::PROD_W_DEF,
    parameter int ACC_W  = pe_acc_pkg::ACC_W_DEF,
    parameter int CNT_W  = $clog2(pe_acc_pkg::MAX_BEATS_DEF) + 1
);
    logic              i_valid;
    logic              i_last;
    logic [PROD_W-1:0] i_prod;
    logic              o_ready;
    logic              o_valid;
    logic              i_ready;
    logic [ACC_W-1:0]  o_acc;
    logic              o_ovf;
    logic              o_err;
    logic [CNT_W-1:0]  o_beats;

    modport slave (
        input  i_valid, i_last, i_prod, i_ready,
        output o_ready, o_valid, o_acc, o_ovf, o_err, o_beats
    );

    modport master (
        output i_valid, i_last, i_prod, i_ready,
        input  o_ready, o_valid, o_acc, o_ovf, o_err, o_beats
    );
endinterface

// File: rtl/pe_acc_add.sv
// Signed ACC_W adder with overflow flag; clamps to the signed range when ACC_SAT_EN is defined.
// Latency: purely combinational.
// Backpressure: none, the caller decides when the sum is captured.
module pe_acc_add #(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] raw;

    // Overflow when both operands share a sign the result does not; clamp direction follows operand sign.
    always_comb begin
        raw = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
`ifdef ACC_SAT_EN
        sum = ovf ? (a[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw;
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/pe_acc_collector.sv
// Accumulates signed PE partial sums over a frame and hands one result per frame downstream (ACC_SAT_EN selects clamp vs wrap).
// Latency: result registered, o_valid rises the cycle after the last beat is accepted; 1 beat/cycle incl. back-to-back frames.
// Backpressure: while a result is held, o_ready follows i_ready so a stalled consumer stalls the PE.
module pe_acc_collector #(
    parameter int PROD_W    = pe_acc_pkg::PROD_W_DEF,
    parameter int ACC_W     = pe_acc_pkg::ACC_W_DEF,
    parameter int MAX_BEATS = pe_acc_pkg::MAX_BEATS_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    pe_acc_collector_if.slave     bus
);
    import pe_acc_pkg::*;

    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] beats_q;
    logic             ovf_q;
    logic             err_q;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] beats_inc;
    logic             beat_take;
    logic             first_last;
    logic             cnt_full;

    assign prod_ext   = ACC_W'(sext64(64'(bus.i_prod), PROD_W));
    assign beats_inc  = beats_q + CNT_W'(1);
    assign cnt_full   = (beats_inc == CNT_W'(MAX_BEATS));
    assign beat_take  = bus.i_valid && bus.o_ready;
    // A one-beat budget closes a frame on its first beat even without i_last.
    assign first_last = bus.i_last || (MAX_BEATS == 1);

    pe_acc_add #(.ACC_W(ACC_W)) u_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: frames close on i_last or when the beat budget is used up.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    state_d = first_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.i_valid && (bus.i_last || cnt_full)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.i_ready) begin
                    if (bus.i_valid) begin
                        state_d = first_last ? HOLD : ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs: a held result only lets a new beat in when the consumer takes it this cycle.
    always_comb begin
        bus.o_valid = 1'b0;
        bus.o_ready = 1'b1;
        if (state_q == HOLD) begin
            bus.o_valid = 1'b1;
            bus.o_ready = bus.i_ready;
        end
    end

    // Datapath: first beat of a frame reloads, later beats add; flags follow the frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q   <= '0;
            beats_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (beat_take) begin
            if (state_q == ACCUM) begin
                acc_q   <= add_sum;
                beats_q <= beats_inc;
                ovf_q   <= ovf_q | add_ovf;
                err_q   <= cnt_full && !bus.i_last;
            end else begin
                acc_q   <= prod_ext;
                beats_q <= CNT_W'(1);
                ovf_q   <= 1'b0;
                err_q   <= (MAX_BEATS == 1) && !bus.i_last;
            end
        end
    end

    assign bus.o_acc   = acc_q;
    assign bus.o_beats = beats_q;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_err   = err_q;

endmodule

// File: tb/tb_pe_acc_collector.sv
// Bench for pe_acc_collector: a wide default instance and a narrow one (ACC_W=14, MAX_BEATS=4).
// Both share the same directed stimulus; a frame-level model predicts each instance's outputs.
// Literal checks pin the hand-computed values of the directed scenarios.
module tb_pe_acc_collector;

    localparam int PW = 13;
    localparam int A0 = 24;
    localparam int M0 = 256;
    localparam int C0 = $clog2(M0) + 1;
    localparam int A1 = 14;
    localparam int M1 = 4;
    localparam int C1 = $clog2(M1) + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          s_vld;
    logic          s_last;
    logic          s_rdy;
    logic [PW-1:0] s_prod;

    pe_acc_collector_if #(.PROD_W(PW), .ACC_W(A0), .CNT_W(C0)) bus0 ();
    pe_acc_collector_if #(.PROD_W(PW), .ACC_W(A1), .CNT_W(C1)) bus1 ();

    assign bus0.i_valid = s_vld;
    assign bus0.i_last  = s_last;
    assign bus0.i_prod  = s_prod;
    assign bus0.i_ready = s_rdy;
    assign bus1.i_valid = s_vld;
    assign bus1.i_last  = s_last;
    assign bus1.i_prod  = s_prod;
    assign bus1.i_ready = s_rdy;

    pe_acc_collector #(.PROD_W(PW), .ACC_W(A0), .MAX_BEATS(M0)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );

    pe_acc_collector #(.PROD_W(PW), .ACC_W(A1), .MAX_BEATS(M1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    int total = 0;
    int bad   = 0;

    // Frame-level model, one slot per instance.
    longint m_acc   [2];
    int     m_beats [2];
    bit     m_open  [2];
    bit     m_ovf   [2];
    bit     m_pend  [2];
    longint r_acc   [2];
    bit     r_ovf   [2];
    bit     r_err   [2];
    int     r_beats [2];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int accw(input int k);
        return (k == 0) ? A0 : A1;
    endfunction

    function automatic int maxb(input int k);
        return (k == 0) ? M0 : M1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_beats[k] = 0; m_open[k] = 0; m_ovf[k] = 0; m_pend[k] = 0;
            r_acc[k] = 0; r_ovf[k] = 0; r_err[k] = 0; r_beats[k] = 0;
        end
    endtask

    // Advance one instance by the clock edge that will sample the current inputs.
    task automatic model_step(input int k);
        longint p, s, mx, mn;
        bit     take;
        p    = longint'($signed(s_prod));
        mx   = (longint'(1) <<< (accw(k) - 1)) - 1;
        mn   = -mx - 1;
        take = s_vld && (!m_pend[k] || s_rdy);
        if (m_pend[k] && s_rdy) m_pend[k] = 0;
        if (take) begin
            if (!m_open[k]) begin
                m_acc[k] = p; m_beats[k] = 1; m_ovf[k] = 0; m_open[k] = 1;
            end else begin
                s = m_acc[k] + p;
                if (s > mx) begin
                    m_ovf[k] = 1;
`ifdef ACC_SAT_EN
                    s = mx;
`else
                    s = s - (longint'(1) <<< accw(k));
`endif
                end else if (s < mn) begin
                    m_ovf[k] = 1;
`ifdef ACC_SAT_EN
                    s = mn;
`else
                    s = s + (longint'(1) <<< accw(k));
`endif
                end
                m_acc[k] = s;
                m_beats[k]++;
            end
            if (s_last || m_beats[k] == maxb(k)) begin
                m_pend[k] = 1; m_open[k] = 0;
                r_acc[k] = m_acc[k]; r_ovf[k] = m_ovf[k];
                r_err[k] = !s_last; r_beats[k] = m_beats[k];
            end
        end
    endtask

    task automatic cmp(input int k, input bit rdy, input bit vld, input longint acc,
                       input bit ovf, input bit err, input longint beats);
        chk($sformatf("o_ready[%0d]", k), rdy, (!m_pend[k] || s_rdy) ? 1 : 0);
        chk($sformatf("o_valid[%0d]", k), vld, m_pend[k]);
        if (m_pend[k]) begin
            chk($sformatf("o_acc[%0d]", k), acc, r_acc[k]);
            chk($sformatf("o_ovf[%0d]", k), ovf, r_ovf[k]);
            chk($sformatf("o_err[%0d]", k), err, r_err[k]);
            chk($sformatf("o_beats[%0d]", k), beats, r_beats[k]);
        end
        if (!rst_n) begin
            chk($sformatf("rst_acc[%0d]", k), acc, 0);
            chk($sformatf("rst_beats[%0d]", k), beats, 0);
            chk($sformatf("rst_flags[%0d]", k), {ovf, err}, 0);
        end
    endtask

    // Compare on the falling edge, then advance the model for the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            cmp(0, bus0.o_ready, bus0.o_valid, longint'($signed(bus0.o_acc)),
                bus0.o_ovf, bus0.o_err, longint'(bus0.o_beats));
            cmp(1, bus1.o_ready, bus1.o_valid, longint'($signed(bus1.o_acc)),
                bus1.o_ovf, bus1.o_err, longint'(bus1.o_beats));
            if (rst_n) begin
                model_step(0);
                model_step(1);
            end
        end
    end

    task automatic drive(input bit v, input bit l, input int p, input bit r);
        @(posedge clk);
        #1;
        s_vld  = v;
        s_last = l;
        s_prod = PW'(p);
        s_rdy  = r;
    endtask

    initial begin
        s_vld = 0; s_last = 0; s_prod = '0; s_rdy = 1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("reset_ready0", bus0.o_ready, 1);
        chk("reset_valid1", bus1.o_valid, 0);

        // Reset in the middle of a 3-beat frame, then a lone +5 frame.
        drive(1, 0, 11, 1); drive(1, 0, 22, 1); drive(1, 0, 33, 1);
        drive(0, 0, 0, 1);
        #1;
        chk("pre_rst_beats", bus0.o_beats, 3);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("rst_valid", bus0.o_valid, 0);
        chk("rst_ready", bus0.o_ready, 1);
        chk("rst_acc",   bus0.o_acc, 0);
        chk("rst_beats", bus0.o_beats, 0);
        @(posedge clk);
        #1 rst_n = 1;
        drive(1, 1, 5, 1);
        drive(0, 0, 0, 0);
        #1;
        chk("one_beat_valid", bus0.o_valid, 1);
        chk("one_beat_acc",   bus0.o_acc, 5);

        // Mixed-sign three-beat frame.
        drive(1, 0, 100, 1); drive(1, 0, -4096, 1); drive(1, 1, 4095, 1);
        #1;
        chk("t2_not_yet", bus0.o_valid, 0);
        drive(0, 0, 0, 0);
        #1;
        chk("t2_valid", bus0.o_valid, 1);
        chk("t2_acc",   longint'($signed(bus0.o_acc)), 99);
        chk("t2_beats", bus0.o_beats, 3);
        chk("t2_ovf",   bus0.o_ovf, 0);
        drive(0, 0, 0, 1);

        // Back-to-back single-beat frames.
        drive(1, 1, 7, 1); drive(1, 1, -3, 1);
        #1;
        chk("t3_first",  bus0.o_acc, 7);
        drive(0, 0, 0, 1);
        #1;
        chk("t3_valid2", bus0.o_valid, 1);
        chk("t3_second", longint'($signed(bus0.o_acc)), -3);
        drive(0, 0, 0, 1);
        #1;
        chk("t3_gone", bus0.o_valid, 0);

        // i_last on its own is ignored.
        drive(0, 1, 123, 1); drive(0, 0, 0, 1);
        #1;
        chk("lone_last", bus0.o_valid, 0);

        // Downstream stall for 4 cycles with a beat waiting.
        drive(1, 1, 10, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 20, 0);
            #1;
            chk("stall_ready", bus0.o_ready, 0);
            chk("stall_acc",   bus0.o_acc, 10);
        end
        drive(1, 1, 20, 1);
        #1;
        chk("release_ready", bus0.o_ready, 1);
        drive(0, 0, 0, 0);
        #1;
        chk("release_acc", bus0.o_acc, 20);
        drive(0, 0, 0, 1);

        // Overflow on the narrow instance.
        drive(1, 0, 4095, 1); drive(1, 0, 4095, 1); drive(1, 1, 4095, 1);
        drive(0, 0, 0, 0);
        #1;
        chk("ovf_flag", bus1.o_ovf, 1);
`ifdef ACC_SAT_EN
        chk("ovf_acc", longint'($signed(bus1.o_acc)), 8191);
`else
        chk("ovf_acc", longint'($signed(bus1.o_acc)), -4099);
`endif
        chk("wide_acc", bus0.o_acc, 12285);
        chk("wide_ovf", bus0.o_ovf, 0);
        drive(0, 0, 0, 1);

        // Beat budget exhaustion on the narrow instance; the fifth beat opens a new frame.
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 1);
        #1;
        chk("max_valid", bus1.o_valid, 1);
        chk("max_acc",   bus1.o_acc, 4);
        chk("max_err",   bus1.o_err, 1);
        chk("max_beats", bus1.o_beats, 4);
        drive(1, 1, 1, 1);
        drive(0, 0, 0, 0);
        #1;
        chk("next_acc",   bus1.o_acc, 2);
        chk("next_beats", bus1.o_beats, 2);
        chk("next_err",   bus1.o_err, 0);
        chk("wide6_acc",  bus0.o_acc, 6);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
